// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
// The optional MULTDIV_EARLY_TERM_EN macro is consumed by multdiv_sequencer, not here.
package multdiv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_DONE
   } state_e;

   localparam int unsigned DEF_MULT_STEPS = 16;
   localparam int unsigned DEF_DIV_STEPS  = 32;
   localparam int          CNT_W          = 6;

endpackage

// File: rtl/multdiv_step_counter.sv
// Iteration counter for the multiply/divide sequencer: sync clear, enable, saturates at all-ones.
module multdiv_step_counter
   import multdiv_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/multdiv_sequencer.sv
// Control FSM sequencing the iterative multiply/divide datapath (IDLE -> LOAD -> RUN -> DONE).
// Define MULTDIV_EARLY_TERM_EN to add the early_done port and early multiply termination.
module multdiv_sequencer
   import multdiv_pkg::*;
#(
   parameter int unsigned MULT_STEPS = DEF_MULT_STEPS,
   parameter int unsigned DIV_STEPS  = DEF_DIV_STEPS
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic             divisor_zero,
   input  logic             mult_overflow,
`ifdef MULTDIV_EARLY_TERM_EN
   input  logic             early_done,
`endif
   output logic             op_load,
   output logic             op_is_div,
   output logic             step_en,
   output logic [CNT_W-1:0] count,
   output logic             busy,
   output logic             data_resultRDY,
   output logic             data_exception
);

   localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

   if ((MULT_STEPS < 1) || (MULT_STEPS > CNT_MAX) ||
       (DIV_STEPS < 1) || (DIV_STEPS > CNT_MAX)) begin : g_bad_steps
      $error("multdiv_sequencer: MULT_STEPS and DIV_STEPS must lie in 1..63");
   end

   localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_STEPS - 1);
   localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_STEPS - 1);

   state_e state_q, state_d;
   logic   op_is_div_q, op_is_div_d;
   logic   dz_flag_q, dz_flag_d;
   logic   op_load_q, op_load_d;
   logic   step_en_q, step_en_d;
   logic   busy_q, busy_d;
   logic   rdy_q, rdy_d;
   logic   first_run;
   logic   last_step;

   multdiv_step_counter u_counter (
      .clock  (clock),
      .reset  (reset),
      .clear  (state_q == ST_LOAD),
      .enable (state_q == ST_RUN),
      .count  (count)
   );

   assign first_run = (count == '0);
   assign last_step = op_is_div_q ? (count == DIV_LAST) : (count == MULT_LAST);

   // A new request restarts from any state; divide has priority over multiply.
   always_comb begin
      state_d     = state_q;
      op_is_div_d = op_is_div_q;
      dz_flag_d   = dz_flag_q;
      if (ctrl_DIV) begin
         state_d     = ST_LOAD;
         op_is_div_d = 1'b1;
      end else if (ctrl_MULT) begin
         state_d     = ST_LOAD;
         op_is_div_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_LOAD: begin
               state_d   = ST_RUN;
               dz_flag_d = 1'b0;
            end
            ST_RUN: begin
               if (first_run) begin
                  dz_flag_d = divisor_zero;
               end
               if (op_is_div_q && first_run && divisor_zero) begin
                  state_d = ST_DONE;
               end else if (last_step) begin
                  state_d = ST_DONE;
`ifdef MULTDIV_EARLY_TERM_EN
               end else if (!op_is_div_q && early_done) begin
                  state_d = ST_DONE;
`endif
               end
            end
            ST_DONE: begin
               state_d     = ST_IDLE;
               op_is_div_d = 1'b0;
            end
            default: state_d = ST_IDLE;
         endcase
      end
      op_load_d = (state_d == ST_LOAD);
      step_en_d = (state_d == ST_RUN);
      busy_d    = (state_d == ST_LOAD) || (state_d == ST_RUN);
      rdy_d     = (state_d == ST_DONE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         op_is_div_q <= 1'b0;
         dz_flag_q   <= 1'b0;
         op_load_q   <= 1'b0;
         step_en_q   <= 1'b0;
         busy_q      <= 1'b0;
         rdy_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_is_div_q <= op_is_div_d;
         dz_flag_q   <= dz_flag_d;
         op_load_q   <= op_load_d;
         step_en_q   <= step_en_d;
         busy_q      <= busy_d;
         rdy_q       <= rdy_d;
      end
   end

   assign op_load        = op_load_q;
   assign op_is_div      = op_is_div_q;
   assign step_en        = step_en_q;
   assign busy           = busy_q;
   assign data_resultRDY = rdy_q;
   // mult_overflow is only valid from the datapath during DONE, so it is gated here.
   assign data_exception = rdy_q & (op_is_div_q ? dz_flag_q : mult_overflow);

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer; covers early termination when MULTDIV_EARLY_TERM_EN is defined.
module tb_multdiv_sequencer;

   localparam int MS = 16;
   localparam int DS = 32;

   logic       clock = 1'b0;
   logic       reset;
   logic       ctrl_MULT;
   logic       ctrl_DIV;
   logic       divisor_zero;
   logic       mult_overflow;
`ifdef MULTDIV_EARLY_TERM_EN
   logic       early_done;
`endif
   logic       op_load;
   logic       op_is_div;
   logic       step_en;
   logic [5:0] count;
   logic       busy;
   logic       data_resultRDY;
   logic       data_exception;

   int checks = 0;
   int errors = 0;

   multdiv_sequencer dut (
      .clock          (clock),
      .reset          (reset),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .divisor_zero   (divisor_zero),
      .mult_overflow  (mult_overflow),
`ifdef MULTDIV_EARLY_TERM_EN
      .early_done     (early_done),
`endif
      .op_load        (op_load),
      .op_is_div      (op_is_div),
      .step_en        (step_en),
      .count          (count),
      .busy           (busy),
      .data_resultRDY (data_resultRDY),
      .data_exception (data_exception)
   );

   always #5 clock = ~clock;

   // Drives a one-cycle request; returns 1 time unit after the sampling edge (E0).
   task automatic issue(input bit is_div, input bit both);
      @(negedge clock);
      ctrl_DIV  = is_div | both;
      ctrl_MULT = !is_div | both;
      @(posedge clock);
      #1;
      ctrl_DIV  = 1'b0;
      ctrl_MULT = 1'b0;
   endtask

   // Reference timeline: cycle t after the request edge. t=0 LOAD, t=1..n RUN, t=n+1 DONE.
   // last_t < 0 means follow through to the first idle cycle after DONE.
   task automatic follow(input string tag, input bit is_div, input bit dz, input bit ovf,
                         input int early_at, input int last_t);
      int         n;
      int         stop_t;
      bit         exp_exc;
      logic [4:0] exp_ctl;
      logic [5:0] exp_cnt;
      if (is_div)             n = dz ? 1 : DS;
      else if (early_at >= 0) n = early_at + 1;
      else                    n = MS;
      exp_exc       = is_div ? dz : ovf;
      stop_t        = (last_t < 0) ? n + 2 : last_t;
      divisor_zero  = dz;
      mult_overflow = ovf;
      for (int t = 0; t <= stop_t; t++) begin
`ifdef MULTDIV_EARLY_TERM_EN
         early_done = (!is_div && (early_at >= 0) && (t == early_at + 1));
`endif
         exp_ctl = {t == 0, (t >= 1) && (t <= n), t <= n, t == n + 1,
                    (t == n + 1) && exp_exc};
         checks++;
         if ({op_load, step_en, busy, data_resultRDY, data_exception} !== exp_ctl) begin
            errors++;
            $display("[TB] FAIL %s t=%0d {load,step,busy,rdy,exc} got %b want %b",
                     tag, t, {op_load, step_en, busy, data_resultRDY, data_exception}, exp_ctl);
         end
         if (t <= n + 1) begin
            checks++;
            if (op_is_div !== is_div) begin
               errors++;
               $display("[TB] FAIL %s t=%0d op_is_div got %b want %b", tag, t, op_is_div, is_div);
            end
         end
         if ((t >= 1) && (t <= n + 1)) begin
            exp_cnt = (t <= n) ? 6'(t - 1) : 6'(n);
            checks++;
            if (count !== exp_cnt) begin
               errors++;
               $display("[TB] FAIL %s t=%0d count got %0d want %0d", tag, t, count, exp_cnt);
            end
         end
         if (t < stop_t) begin
            @(posedge clock);
            #1;
         end
      end
`ifdef MULTDIV_EARLY_TERM_EN
      early_done = 1'b0;
`endif
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      ctrl_MULT = 1'b1;
      ctrl_DIV  = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if ({op_load, op_is_div, step_en, busy, data_resultRDY, data_exception, count} !== 12'd0) begin
         errors++;
         $display("[TB] FAIL reset outputs got %b want 0",
                  {op_load, op_is_div, step_en, busy, data_resultRDY, data_exception, count});
      end
      @(negedge clock);
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
      reset     = 1'b0;
   endtask

   task automatic test_multiply();
      issue(1'b0, 1'b0);
      follow("mul", 1'b0, 1'b0, 1'b0, -1, -1);
      issue(1'b0, 1'b0);
      follow("mul_ovf", 1'b0, 1'b1, 1'b1, -1, -1);
   endtask

   task automatic test_divide();
      issue(1'b1, 1'b0);
      follow("div_zero", 1'b1, 1'b1, 1'b0, -1, -1);
      issue(1'b1, 1'b0);
      follow("div", 1'b1, 1'b0, 1'b1, -1, -1);
   endtask

   task automatic test_restart();
      issue(1'b0, 1'b0);
      follow("restart_mul", 1'b0, 1'b0, 1'b0, -1, 6);
      issue(1'b1, 1'b0);
      follow("restart_div", 1'b1, 1'b0, 1'b0, -1, -1);
   endtask

   task automatic test_simultaneous();
      issue(1'b1, 1'b1);
      follow("both", 1'b1, 1'b0, 1'b0, -1, -1);
   endtask

   task automatic test_reset_midrun();
      issue(1'b0, 1'b0);
      follow("rst_run", 1'b0, 1'b0, 1'b0, -1, 11);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      checks++;
      if ({op_load, op_is_div, step_en, busy, data_resultRDY, data_exception, count} !== 12'd0) begin
         errors++;
         $display("[TB] FAIL reset_midrun outputs got %b want 0",
                  {op_load, op_is_div, step_en, busy, data_resultRDY, data_exception, count});
      end
      @(negedge clock);
      reset = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clock);
         #1;
         checks++;
         if ({data_resultRDY, busy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_quiet cycle %0d {rdy,busy} got %b want 00",
                     c, {data_resultRDY, busy});
         end
      end
   endtask

`ifdef MULTDIV_EARLY_TERM_EN
   task automatic test_early_term();
      int k;
      issue(1'b0, 1'b0);
      follow("early3", 1'b0, 1'b0, 1'b0, 3, -1);
      issue(1'b1, 1'b0);
      follow("early_div_ignored", 1'b1, 1'b0, 1'b0, -1, -1);
      for (int i = 0; i < 4; i++) begin
         k = $urandom_range(0, MS - 2);
         issue(1'b0, 1'b0);
         follow("early_rand", 1'b0, 1'b0, 1'($urandom_range(0, 1)), k, -1);
      end
   endtask
`endif

   task automatic test_back_to_back();
      bit is_div;
      bit both;
      int gap;
      for (int i = 0; i < 20; i++) begin
         is_div = 1'($urandom_range(0, 1));
         both   = is_div & 1'($urandom_range(0, 1));
         gap    = $urandom_range(0, 2);
         issue(is_div, both);
         follow("b2b", is_div, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, -1);
         repeat (gap) @(posedge clock);
      end
   endtask

   initial begin
      reset         = 1'b1;
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      divisor_zero  = 1'b0;
      mult_overflow = 1'b0;
`ifdef MULTDIV_EARLY_TERM_EN
      early_done    = 1'b0;
`endif
      test_reset();
      test_multiply();
      test_divide();
      test_restart();
      test_simultaneous();
      test_reset_midrun();
`ifdef MULTDIV_EARLY_TERM_EN
      test_early_term();
`endif
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
